serial_frame_tx: RTL and testbench

SERIAL_FRAME_TX -- requirements
Module: serial_frame_tx

---
 rtl/serial_frame_tx.sv | 155 +++++++++++++++
 tb/tb_serial_frame_tx.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_frame_tx.sv
// serial_frame_tx: transmit side of the serial-frame format.
// A frame is a start bit (0), 8 data bits LSB first, an optional odd-parity bit
// and a stop bit (1). Each bit is held on txd for BIT_CYCLES clock cycles.
//
// Ports:
//   clk       - clock; all state changes on its rising edge
//   reset     - asynchronous active-high reset
//   in_valid  - a byte is offered on in_data
//   in_data   - byte to transmit
//   in_ready  - high while idle; a byte is accepted at an edge with in_valid=1
//   txd       - registered serial line, idle high
//   busy      - high while a frame is in progress
//   done      - one-cycle pulse starting at the edge that ends the stop bit
module serial_frame_tx #(
  parameter int unsigned BIT_CYCLES = 1,
  parameter int unsigned PARITY_ODD = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       txd,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } state_e;

  // Counter runs BIT_CYCLES-1 down to 0; a bit boundary is the edge where it reads 0.
  localparam logic [15:0] CntReload = 16'(BIT_CYCLES - 1);
  localparam bit          HasParity = (PARITY_ODD != 0);

  state_e      r_state, w_state_d;
  logic [15:0] r_cnt,   w_cnt_d;
  logic [2:0]  r_idx,   w_idx_d;
  logic [7:0]  r_data,  w_data_d;
  logic        r_par,   w_par_d;
  logic        r_txd,   w_txd_d;
  logic        r_done,  w_done_d;

  logic        w_tick;
  logic [2:0]  w_idx_inc;

  assign w_tick    = (r_cnt == 16'd0);
  assign w_idx_inc = r_idx + 3'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= StIdle;
      r_cnt   <= 16'd0;
      r_idx   <= 3'd0;
      r_data  <= 8'd0;
      r_par   <= 1'b0;
      r_txd   <= 1'b1;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
      r_idx   <= w_idx_d;
      r_data  <= w_data_d;
      r_par   <= w_par_d;
      r_txd   <= w_txd_d;
      r_done  <= w_done_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    w_idx_d   = r_idx;
    w_data_d  = r_data;
    w_par_d   = r_par;
    w_txd_d   = r_txd;
    w_done_d  = 1'b0;

    // Inside a bit: count down and hold txd.
    if (r_state != StIdle && !w_tick) begin
      w_cnt_d = r_cnt - 16'd1;
    end

    unique case (r_state)
      StIdle: begin
        w_txd_d = 1'b1;
        if (in_valid) begin
          w_state_d = StStart;
          w_data_d  = in_data;
          w_par_d   = ~^in_data;
          w_idx_d   = 3'd0;
          w_cnt_d   = CntReload;
          w_txd_d   = 1'b0;
        end
      end
      StStart: begin
        if (w_tick) begin
          w_state_d = StData;
          w_idx_d   = 3'd0;
          w_cnt_d   = CntReload;
          w_txd_d   = r_data[0];
        end
      end
      StData: begin
        if (w_tick) begin
          w_cnt_d = CntReload;
          if (r_idx == 3'd7) begin
            if (HasParity) begin
              w_state_d = StParity;
              w_txd_d   = r_par;
            end else begin
              w_state_d = StStop;
              w_txd_d   = 1'b1;
            end
          end else begin
            w_idx_d = w_idx_inc;
            w_txd_d = r_data[w_idx_inc];
          end
        end
      end
      StParity: begin
        if (w_tick) begin
          w_state_d = StStop;
          w_cnt_d   = CntReload;
          w_txd_d   = 1'b1;
        end
      end
      StStop: begin
        if (w_tick) begin
          w_state_d = StIdle;
          w_cnt_d   = 16'd0;
          w_txd_d   = 1'b1;
          w_done_d  = 1'b1;
        end
      end
      default: begin
        // Unreachable encodings recover to idle with the line high.
        w_state_d = StIdle;
        w_cnt_d   = 16'd0;
        w_idx_d   = 3'd0;
        w_txd_d   = 1'b1;
      end
    endcase
  end

  assign in_ready = (r_state == StIdle);
  assign busy     = (r_state != StIdle);
  assign txd      = r_txd;
  assign done     = r_done;

endmodule

// File: tb/tb_serial_frame_tx.sv
// Testbench for serial_frame_tx. Two instances share clock and reset:
// u_dut1 (BIT_CYCLES=1, parity on) and u_dut4 (BIT_CYCLES=4, parity off).
module tb_serial_frame_tx;

  logic       clk = 1'b0;
  logic       reset = 1'b0;

  logic       v1 = 1'b0;
  logic [7:0] d1 = 8'd0;
  logic       rdy1, txd1, busy1, done1;

  logic       v4 = 1'b0;
  logic [7:0] d4 = 8'd0;
  logic       rdy4, txd4, busy4, done4;

  int n_checks = 0;
  int n_fail   = 0;
  int n_done1  = 0;
  int n_done4  = 0;

  always #5 clk = ~clk;

  serial_frame_tx #(.BIT_CYCLES(1), .PARITY_ODD(1)) u_dut1 (
    .clk      (clk),
    .reset    (reset),
    .in_valid (v1),
    .in_data  (d1),
    .in_ready (rdy1),
    .txd      (txd1),
    .busy     (busy1),
    .done     (done1)
  );

  serial_frame_tx #(.BIT_CYCLES(4), .PARITY_ODD(0)) u_dut4 (
    .clk      (clk),
    .reset    (reset),
    .in_valid (v4),
    .in_data  (d4),
    .in_ready (rdy4),
    .txd      (txd4),
    .busy     (busy4),
    .done     (done4)
  );

  always @(posedge clk) begin
    if (done1 === 1'b1) n_done1++;
    if (done4 === 1'b1) n_done4++;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Vectors for the BIT_CYCLES=1 parity instance. frame bit i = txd in cycle i after
  // the accept edge: {stop, parity, data[7:0], start}.
  typedef struct {
    logic [7:0]  data;
    logic [10:0] frame;
    bit          toggle;
  } vec1_t;

  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;
  } vec4_t;

  vec1_t vecs1[6];
  vec4_t vecs4[2];

  task automatic wait_ready1(input string tag);
    int w = 0;
    while (rdy1 !== 1'b1 && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk({tag, " ready"}, 32'(rdy1), 32'd1);
  endtask

  // Offer a byte, then check all 11 bit cycles and the done cycle. With toggle set,
  // in_valid/in_data keep changing during the frame and must be ignored.
  task automatic send1(input logic [7:0] data, input logic [10:0] frame, input bit toggle,
                       input string tag);
    wait_ready1(tag);
    v1 = 1'b1;
    d1 = data;
    @(posedge clk);
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      chk($sformatf("%s txd c%0d", tag, i), 32'(txd1), 32'(frame[i]));
      chk($sformatf("%s busy c%0d", tag, i), 32'(busy1), 32'd1);
      chk($sformatf("%s done c%0d", tag, i), 32'(done1), 32'd0);
      if (toggle) begin
        v1 = ~v1;
        d1 = 8'($urandom);
      end else begin
        v1 = 1'b0;
      end
    end
    @(negedge clk);
    v1 = 1'b0;
    chk({tag, " done end"}, 32'(done1), 32'd1);
    chk({tag, " busy end"}, 32'(busy1), 32'd0);
    chk({tag, " ready end"}, 32'(rdy1), 32'd1);
    chk({tag, " txd end"}, 32'(txd1), 32'd1);
    @(negedge clk);
    chk({tag, " done drop"}, 32'(done1), 32'd0);
    chk({tag, " idle txd"}, 32'(txd1), 32'd1);
  endtask

  initial begin
    int d0;
    logic [10:0] fr;

    vecs1[0] = '{data: 8'h5A, frame: 11'b11010110100, toggle: 1'b0};
    vecs1[1] = '{data: 8'h00, frame: 11'b11000000000, toggle: 1'b0};
    vecs1[2] = '{data: 8'hFF, frame: 11'b11111111110, toggle: 1'b0};
    vecs1[3] = '{data: 8'h80, frame: 11'b10100000000, toggle: 1'b0};
    vecs1[4] = '{data: 8'h07, frame: 11'b10000001110, toggle: 1'b1};
    vecs1[5] = '{data: 8'h3C, frame: 11'b11001111000, toggle: 1'b1};
    vecs4[0] = '{data: 8'h01, frame: 10'b1000000010};
    vecs4[1] = '{data: 8'hC3, frame: 10'b1110000110};

    // Asynchronous reset between edges.
    #2 reset = 1'b1;
    #1;
    chk("rst txd1", 32'(txd1), 32'd1);
    chk("rst rdy1", 32'(rdy1), 32'd1);
    chk("rst busy1", 32'(busy1), 32'd0);
    chk("rst done1", 32'(done1), 32'd0);
    chk("rst txd4", 32'(txd4), 32'd1);
    chk("rst busy4", 32'(busy4), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Table-driven frames, BIT_CYCLES=1 with parity.
    for (int k = 0; k < 6; k++) begin
      send1(vecs1[k].data, vecs1[k].frame, vecs1[k].toggle, $sformatf("v1_%0d", k));
    end

    // Table-driven frames, BIT_CYCLES=4 without parity: 40 cycles per frame.
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("v4_%0d ready", k), 32'(rdy4), 32'd1);
      v4 = 1'b1;
      d4 = vecs4[k].data;
      @(posedge clk);
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        v4 = 1'b0;
        chk($sformatf("v4_%0d txd c%0d", k, i), 32'(txd4), 32'(vecs4[k].frame[i / 4]));
        chk($sformatf("v4_%0d busy c%0d", k, i), 32'(busy4), 32'd1);
        chk($sformatf("v4_%0d done c%0d", k, i), 32'(done4), 32'd0);
      end
      @(negedge clk);
      chk($sformatf("v4_%0d done end", k), 32'(done4), 32'd1);
      chk($sformatf("v4_%0d busy end", k), 32'(busy4), 32'd0);
      chk($sformatf("v4_%0d txd end", k), 32'(txd4), 32'd1);
      @(negedge clk);
    end

    // Back-to-back: 0x00 then 0xFF with in_valid held high.
    wait_ready1("b2b");
    d0 = n_done1;
    v1 = 1'b1;
    d1 = 8'h00;
    fr = 11'b11000000000;
    @(posedge clk);
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      d1 = 8'hFF;
      chk($sformatf("b2b f0 txd c%0d", i), 32'(txd1), 32'(fr[i]));
    end
    @(negedge clk);
    chk("b2b gap done", 32'(done1), 32'd1);
    chk("b2b gap txd", 32'(txd1), 32'd1);
    chk("b2b gap ready", 32'(rdy1), 32'd1);
    fr = 11'b11111111110;
    @(posedge clk);
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      v1 = 1'b0;
      chk($sformatf("b2b f1 txd c%0d", i), 32'(txd1), 32'(fr[i]));
      chk($sformatf("b2b f1 busy c%0d", i), 32'(busy1), 32'd1);
    end
    @(negedge clk);
    chk("b2b f1 done", 32'(done1), 32'd1);
    @(negedge clk);
    chk("b2b done count", 32'(n_done1 - d0), 32'd2);
    chk("b2b idle", 32'(busy1), 32'd0);

    // Reset during data bit 3 of 0xA5, then a clean 0x3C frame.
    wait_ready1("abort");
    d0 = n_done1;
    fr = 11'b11101001010;
    v1 = 1'b1;
    d1 = 8'hA5;
    @(posedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      v1 = 1'b0;
      chk($sformatf("abort txd c%0d", i), 32'(txd1), 32'(fr[i]));
    end
    #2 reset = 1'b1;
    #1;
    chk("abort txd", 32'(txd1), 32'd1);
    chk("abort busy", 32'(busy1), 32'd0);
    chk("abort ready", 32'(rdy1), 32'd1);
    chk("abort done", 32'(done1), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort no done", 32'(n_done1 - d0), 32'd0);
    chk("abort idle txd", 32'(txd1), 32'd1);
    send1(8'h3C, 11'b11001111000, 1'b0, "post_abort");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
